// File: rtl/szukanie_bitu.sv
// szukanie_bitu: sequential highest-set-bit finder (inverse of bit-set).
// Scans the latched operand one bit per clock from the MSB downwards and
// reports the index of the first set bit found, or an error when the word
// is zero. Start/valid handshake; all outputs come straight from registers.
module szukanie_bitu #(
    parameter int BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [BITS-1:0] i_arg_A,
    output logic [BITS-1:0] o_result,
    output logic            o_error,
    output logic            o_valid,
    output logic            o_busy
);

    localparam int IDXW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [BITS-1:0]   r_a;
    logic [IDXW-1:0]   r_idx;
    logic [BITS-1:0]   r_result;
    logic              r_error;
    logic              r_valid;

    state_t            w_state_next;
    logic [BITS-1:0]   w_a_next;
    logic [IDXW-1:0]   w_idx_next;
    logic [BITS-1:0]   w_result_next;
    logic              w_error_next;
    logic              w_valid_next;

    // State and datapath registers; reset discards any scan in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_a      <= w_a_next;
            r_idx    <= w_idx_next;
            r_result <= w_result_next;
            r_error  <= w_error_next;
            r_valid  <= w_valid_next;
        end
    end

    // Next-state logic: accept in IDLE, test one bit per cycle in SCAN,
    // stop on the first set bit or after bit 0, then a single DONE cycle.
    always_comb begin
        w_state_next  = r_state;
        w_a_next      = r_a;
        w_idx_next    = r_idx;
        w_result_next = r_result;
        w_error_next  = r_error;
        w_valid_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_a_next     = i_arg_A;
                    w_idx_next   = IDX_MAX;
                    w_error_next = 1'b0;
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (r_a[r_idx]) begin
                    w_result_next = BITS'(r_idx);
                    w_error_next  = 1'b0;
                    w_valid_next  = 1'b1;
                    w_state_next  = DONE;
                end else if (r_idx == '0) begin
                    w_result_next = '0;
                    w_error_next  = 1'b1;
                    w_valid_next  = 1'b1;
                    w_state_next  = DONE;
                end else begin
                    w_idx_next = r_idx - 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_result = r_result;
    assign o_error  = r_error;
    assign o_valid  = r_valid;
    assign o_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_szukanie_bitu.sv
// Testbench for szukanie_bitu: directed extremes plus random operands,
// checked against a floor(log2) reference model with expected latencies.
module tb_szukanie_bitu;

    localparam int BITS = 32;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_start;
    logic [BITS-1:0] i_arg_A;
    logic [BITS-1:0] o_result;
    logic            o_error;
    logic            o_valid;
    logic            o_busy;

    int total;
    int bad;

    szukanie_bitu #(.BITS(BITS)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_arg_A  (i_arg_A),
        .o_result (o_result),
        .o_error  (o_error),
        .o_valid  (o_valid),
        .o_busy   (o_busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Reference: floor(log2(a)) by repeated halving, -1 for zero.
    function automatic int model_index(input logic [BITS-1:0] a);
        logic [BITS-1:0] v;
        int n;
        v = a;
        n = 0;
        if (v == '0) return -1;
        while (v > 1) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    function automatic int model_latency(input logic [BITS-1:0] a);
        int k;
        k = model_index(a);
        return (k < 0) ? BITS : BITS - k;
    endfunction

    // Drives one accepted operation and measures it; optionally pulses
    // i_start with another operand in cycle injCycle after acceptance.
    task automatic run_op(
        input  logic [BITS-1:0] a,
        input  int              injCycle,
        input  logic [BITS-1:0] injA,
        output int              lat,
        output int              vcount,
        output logic [BITS-1:0] res,
        output logic            err,
        output logic            busyAfterAccept,
        output logic            errAfterAccept,
        output logic            busyEnd,
        output logic [BITS-1:0] resEnd
    );
        lat    = -1;
        vcount = 0;
        res    = '0;
        err    = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_arg_A = a;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        i_arg_A = $urandom;
        busyAfterAccept = o_busy;
        errAfterAccept  = o_error;
        for (int c = 1; c <= BITS + 3; c++) begin
            if (c == injCycle) begin
                i_start = 1'b1;
                i_arg_A = injA;
            end else begin
                i_start = 1'b0;
                i_arg_A = $urandom;
            end
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_valid) begin
                vcount++;
                if (lat < 0) begin
                    lat = c;
                    res = o_result;
                    err = o_error;
                end
            end
        end
        i_start = 1'b0;
        busyEnd = o_busy;
        resEnd  = o_result;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_arg_A = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            total++;
            if ({o_result, o_error, o_valid, o_busy} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_hold cycle %0d: got res=%0d err=%b v=%b busy=%b, need all 0",
                         c, o_result, o_error, o_valid, o_busy);
            end
        end
        i_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            total++;
            if ({o_result, o_error, o_valid, o_busy} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_idle cycle %0d: got res=%0d err=%b v=%b busy=%b, need all 0",
                         c, o_result, o_error, o_valid, o_busy);
            end
        end
    endtask

    // Checks one operation's outcome against the model, inline.
    task automatic test_operand(input string name, input logic [BITS-1:0] a);
        int lat, vcount, expIdx, expLat;
        logic [BITS-1:0] res, resEnd, expRes;
        logic err, busyA, errA, busyEnd, expErr;
        expIdx = model_index(a);
        expLat = model_latency(a);
        expRes = (expIdx < 0) ? '0 : BITS'(expIdx);
        expErr = (expIdx < 0);
        run_op(a, -1, '0, lat, vcount, res, err, busyA, errA, busyEnd, resEnd);
        total++;
        if (lat !== expLat) begin
            bad++;
            $display("[TB] FAIL %s_latency A=%h: got %0d, need %0d", name, a, lat, expLat);
        end
        total++;
        if (res !== expRes || err !== expErr) begin
            bad++;
            $display("[TB] FAIL %s_result A=%h: got res=%0d err=%b, need res=%0d err=%b",
                     name, a, res, err, expRes, expErr);
        end
        total++;
        if (vcount !== 1) begin
            bad++;
            $display("[TB] FAIL %s_valid_count A=%h: got %0d, need 1", name, a, vcount);
        end
        total++;
        if (busyA !== 1'b1 || errA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_accept A=%h: got busy=%b err=%b, need busy=1 err=0",
                     name, a, busyA, errA);
        end
        total++;
        if (busyEnd !== 1'b0 || resEnd !== expRes) begin
            bad++;
            $display("[TB] FAIL %s_hold A=%h: got busy=%b res=%0d, need busy=0 res=%0d",
                     name, a, busyEnd, resEnd, expRes);
        end
    endtask

    task automatic test_extremes();
        test_operand("msb", 32'hFFFF_FFFF);
        test_operand("lsb", 32'h0000_0001);
    endtask

    task automatic test_zero();
        test_operand("zero", 32'h0000_0000);
        test_operand("after_zero", 32'h0000_0100);
    endtask

    task automatic test_random();
        logic [BITS-1:0] a;
        for (int i = 0; i < 6; i++) begin
            a = BITS'($urandom) >> $urandom_range(0, BITS - 1);
            if (a == '0) a = 32'h0000_0001;
            test_operand("random", a);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, vcount;
        logic [BITS-1:0] res, resEnd;
        logic err, busyA, errA, busyEnd;
        run_op(32'h0000_0010, 5, 32'h8000_0000, lat, vcount, res, err, busyA, errA, busyEnd, resEnd);
        total++;
        if (res !== 32'd4 || err !== 1'b0 || lat !== 28) begin
            bad++;
            $display("[TB] FAIL busy_ignore: got res=%0d err=%b lat=%0d, need res=4 err=0 lat=28",
                     res, err, lat);
        end
        total++;
        if (vcount !== 1) begin
            bad++;
            $display("[TB] FAIL busy_valid_count: got %0d, need 1", vcount);
        end
        test_operand("after_busy", 32'h8000_0000);
    endtask

    // Start held high continuously: accepts land only in IDLE, so valid
    // appears after edges 1, 4 and 7 (edge 0 is the first acceptance).
    task automatic test_back_to_back();
        logic [8:0] pattern;
        logic [8:0] expected;
        expected = 9'b010010010;
        pattern  = '0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_arg_A = 32'h8000_0000;
        for (int c = 0; c < 9; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            pattern[c] = o_valid;
        end
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        total++;
        if (pattern !== expected) begin
            bad++;
            $display("[TB] FAIL back_to_back_valid: got %b, need %b", pattern, expected);
        end
    endtask

    task automatic test_reset_mid_op();
        int validSeen;
        int busySeen;
        @(negedge i_clk);
        i_start = 1'b1;
        i_arg_A = 32'h0000_0002;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (10) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({o_result, o_error, o_valid, o_busy} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid_async: got res=%0d err=%b v=%b busy=%b, need all 0",
                     o_result, o_error, o_valid, o_busy);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        validSeen = 0;
        busySeen  = 0;
        for (int c = 0; c < BITS + 5; c++) begin
            @(negedge i_clk);
            if (o_valid) validSeen++;
            if (o_busy) busySeen++;
        end
        total++;
        if (validSeen !== 0 || busySeen !== 0) begin
            bad++;
            $display("[TB] FAIL reset_mid_after: got valid=%0d busy=%0d cycles, need 0 and 0",
                     validSeen, busySeen);
        end
    endtask

    // Sequence of scenarios followed by the single summary line.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_extremes();
        test_zero();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/szukanie_bitu.md
Name: szukanie_bitu

Overview:
Sequential inverse of the bit-set operation in the synchronous arithmetic unit. The bit-set operation turns an index into a set bit. This block takes a word and returns the index of its highest set bit. It scans i_arg_A one bit per clock, starting at the MSB, under a start/valid handshake. It sits beside the combinational operation modules and shares their o_result/o_error output convention.

Parameters:
BITS, 32, operand and result width; the scan index range is 0..BITS-1.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  request pulse; sampled only in IDLE.
i_arg_A  input  BITS  word to scan; sampled on the edge that accepts i_start.
o_result  output  BITS  index of highest set bit, zero-extended to BITS.
o_error  output  1  1 = i_arg_A was zero, so no set bit exists.
o_valid  output  1  one-cycle pulse: o_result/o_error are fresh.
o_busy  output  1  1 while in SCAN or DONE.

Behaviour:
- Reset (i_rst_n=0, asynchronous, any state, any time):
  - state=IDLE; internal registers cleared.
  - o_result=0, o_error=0, o_valid=0, o_busy=0.
  - Reset mid-scan discards the operation; no o_valid follows.
- State IDLE:
  - o_busy=0.
  - On an edge with i_start=1: latch A_reg=i_arg_A, idx=BITS-1, clear o_error, go to SCAN.
  - i_start=0 keeps IDLE.
- State SCAN (o_busy=1), one bit per edge:
  - A_reg[idx]=1: o_result<=idx, o_error<=0, o_valid<=1, go to DONE.
  - Else if idx=0: o_result<=0, o_error<=1, o_valid<=1, go to DONE.
  - Else idx<=idx-1.
- State DONE (o_busy=1): lasts exactly one cycle. o_valid is high during it. Next edge: o_valid<=0, go to IDLE.
- Latency: let E0 be the accepting edge. Highest set bit k gives o_valid high after edge E(BITS-k).
  - Bit BITS-1 set: 1 cycle.
  - Only bit 0 set: BITS cycles.
  - A=0: BITS cycles, with o_error=1.
- i_start while busy (SCAN or DONE) is ignored: no queueing, latched A_reg is unaffected. A new start is accepted no earlier than the first IDLE cycle after DONE.
- Changes on i_arg_A after acceptance have no effect.
- o_result and o_error hold their last value after DONE until the next accepted start. o_error clears on accept; o_result updates only in SCAN completion.
- o_valid is never high for more than one consecutive cycle.
- Index arithmetic is unsigned. idx never wraps below 0, because termination at idx=0 is mandatory.
- All outputs are registered; no combinational path from inputs to outputs.
- Round-trip property: if A≠0, setting bit o_result in a zero word with the bit-set operation yields the MSB-isolated A.

Test Plan:
- Reset then idle: hold i_rst_n=0 for 3 cycles, release, i_start=0 for 5 cycles -> all outputs stay 0, o_busy=0.
- MSB and LSB extremes (BITS=32):
  - A=32'hFFFF_FFFF -> o_valid 1 cycle after accept, o_result=31, o_error=0.
  - A=32'h0000_0001 -> o_valid after 32 cycles, o_result=0, o_error=0.
- Zero operand: A=0 -> o_valid after 32 cycles, o_error=1, o_result=0. A following start with A=32'h0000_0100 -> o_result=8, o_error=0.
- Random sweep: 6 random nonzero A -> o_result = floor(log2(A)), latency 32-o_result cycles, results checked against a behavioural model.
- Start while busy: accept A=32'h0000_0010, pulse i_start with A=32'h8000_0000 during SCAN -> ignored; o_result=4 with exactly one o_valid. Next start with A=32'h8000_0000 in IDLE -> o_result=31.
- Reset mid-operation: A=32'h0000_0002, drop i_rst_n asynchronously (between edges) 10 cycles after accept -> outputs 0 immediately, state IDLE, no o_valid after release.
